// File: rtl/piped_sub_mod.sv
// Pipelined modular subtractor: out0 = (in0 - in1) mod P, chunk-serial borrow then chunk-serial +P fix-up.
// Optional range check (err_o) built only when PIPED_SUB_MOD_RANGE_CHECK_EN is defined.
module piped_sub_mod #(
  parameter int unsigned  W = 384,
  parameter int unsigned  C = 2,
  parameter int unsigned  M = 1,
  parameter logic [W-1:0] P = 384'h01ae3a4617c510eac63b05c06ca1493b1a22d9f300f5138f1ef3622fba094800170b5d44300000008508c00000000001
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  input  logic [W-1:0] in0,
  input  logic [W-1:0] in1,
  input  logic [M-1:0] m_i,
  output logic         out_valid,
  output logic [W-1:0] out0,
  output logic [M-1:0] m_o
`ifdef PIPED_SUB_MOD_RANGE_CHECK_EN
  ,
  output logic         err_o
`endif
);

  localparam int unsigned D  = 1 << C;
  localparam int unsigned CW = (W + D - 1) / D;

  // Stage A boundaries: index j is the input of subtract stage j.
  logic [W-1:0] sa_dat [D+1];
  logic [W-1:0] sa_sub [D];
  logic         sa_brw [D+1];
  logic         sa_vld [D+1];
  logic [M-1:0] sa_met [D+1];

  assign sa_dat[0] = in0;
  assign sa_sub[0] = in1;
  assign sa_brw[0] = 1'b0;
  assign sa_vld[0] = in_valid;
  assign sa_met[0] = m_i;

`ifdef PIPED_SUB_MOD_RANGE_CHECK_EN
  // Borrow chains of in0 - P and in1 - P; no final borrow means operand >= P.
  logic sa_g0 [D+1];
  logic sa_g1 [D+1];
  assign sa_g0[0] = 1'b0;
  assign sa_g1[0] = 1'b0;
`endif

  for (genvar j = 0; j < D; j++) begin : g_sub
    localparam int unsigned LO  = j * CW;
    localparam int unsigned CWJ = (j == D - 1) ? W - LO : CW;

    logic [CWJ:0]   diff;
    logic [W-1:0]   dat_d;
    logic [W-1:0]   dat_q;
    logic           brw_q;
    logic           vld_q;
    logic [M-1:0]   met_q;

    assign diff = {1'b0, sa_dat[j][LO +: CWJ]} - {1'b0, sa_sub[j][LO +: CWJ]}
                - (CWJ + 1)'(sa_brw[j]);

    always_comb begin
      // NOTE: default the whole word first so every bit is assigned on every path (no latch).
      dat_d            = sa_dat[j];
      dat_d[LO +: CWJ] = diff[CWJ-1:0];
    end

    always_ff @(posedge clk) begin
      // NOTE: data and metadata clear on reset too, so out0/m_o read 0 straight after reset.
      if (!rst) begin
        vld_q <= 1'b0;
        dat_q <= '0;
        brw_q <= 1'b0;
        met_q <= '0;
      end else begin
        vld_q <= sa_vld[j];
        dat_q <= dat_d;
        brw_q <= diff[CWJ];
        met_q <= sa_met[j];
      end
    end

    assign sa_dat[j+1] = dat_q;
    assign sa_brw[j+1] = brw_q;
    assign sa_vld[j+1] = vld_q;
    assign sa_met[j+1] = met_q;

    if (j < D - 1) begin : g_skew
      logic [W-1:0] sub_q;
      always_ff @(posedge clk) begin
        if (!rst) sub_q <= '0;
        else      sub_q <= sa_sub[j];
      end
      assign sa_sub[j+1] = sub_q;
    end

`ifdef PIPED_SUB_MOD_RANGE_CHECK_EN
    logic g0_d, g1_d, g0_q, g1_q;
    assign g0_d = (sa_dat[j][LO +: CWJ] < P[LO +: CWJ])
                | ((sa_dat[j][LO +: CWJ] == P[LO +: CWJ]) & sa_g0[j]);
    assign g1_d = (sa_sub[j][LO +: CWJ] < P[LO +: CWJ])
                | ((sa_sub[j][LO +: CWJ] == P[LO +: CWJ]) & sa_g1[j]);
    always_ff @(posedge clk) begin
      if (!rst) begin
        g0_q <= 1'b0;
        g1_q <= 1'b0;
      end else begin
        g0_q <= g0_d;
        g1_q <= g1_d;
      end
    end
    assign sa_g0[j+1] = g0_q;
    assign sa_g1[j+1] = g1_q;
`endif
  end

  // Stage B boundaries: index j is the input of correction stage j.
  logic [W-1:0] sb_dat [D+1];
  logic         sb_ba  [D];
  logic         sb_cy  [D];
  logic         sb_vld [D+1];
  logic [M-1:0] sb_met [D+1];

  assign sb_dat[0] = sa_dat[D];
  assign sb_ba[0]  = sa_brw[D];
  assign sb_cy[0]  = 1'b0;
  assign sb_vld[0] = sa_vld[D];
  assign sb_met[0] = sa_met[D];

`ifdef PIPED_SUB_MOD_RANGE_CHECK_EN
  logic sb_bad [D];
  assign sb_bad[0] = ~sa_g0[D] | ~sa_g1[D];
`endif

  for (genvar j = 0; j < D; j++) begin : g_fix
    localparam int unsigned LO  = j * CW;
    localparam int unsigned CWJ = (j == D - 1) ? W - LO : CW;

    logic [CWJ-1:0] addend;
    logic [CWJ-1:0] chunk;
    logic [W-1:0]   dat_d;
    logic [W-1:0]   dat_q;
    logic           vld_q;
    logic [M-1:0]   met_q;

    assign addend = sb_ba[j] ? P[LO +: CWJ] : '0;

    if (j < D - 1) begin : g_carry
      logic [CWJ:0] sum;
      logic         ba_q;
      logic         cy_q;
      assign sum   = {1'b0, sb_dat[j][LO +: CWJ]} + {1'b0, addend} + (CWJ + 1)'(sb_cy[j]);
      assign chunk = sum[CWJ-1:0];
      always_ff @(posedge clk) begin
        if (!rst) begin
          ba_q <= 1'b0;
          cy_q <= 1'b0;
        end else begin
          ba_q <= sb_ba[j];
          cy_q <= sum[CWJ];
        end
      end
      assign sb_ba[j+1] = ba_q;
      assign sb_cy[j+1] = cy_q;
`ifdef PIPED_SUB_MOD_RANGE_CHECK_EN
      logic bad_q;
      always_ff @(posedge clk) begin
        if (!rst) bad_q <= 1'b0;
        else      bad_q <= sb_bad[j];
      end
      assign sb_bad[j+1] = bad_q;
`endif
    end else begin : g_last
      // Carry out of the top chunk is dropped: d + P wraps modulo 2^W.
      assign chunk = sb_dat[j][LO +: CWJ] + addend + CWJ'(sb_cy[j]);
    end

    always_comb begin
      dat_d            = sb_dat[j];
      dat_d[LO +: CWJ] = chunk;
    end

    always_ff @(posedge clk) begin
      if (!rst) begin
        vld_q <= 1'b0;
        dat_q <= '0;
        met_q <= '0;
      end else begin
        vld_q <= sb_vld[j];
        dat_q <= dat_d;
        met_q <= sb_met[j];
      end
    end

    assign sb_dat[j+1] = dat_q;
    assign sb_vld[j+1] = vld_q;
    assign sb_met[j+1] = met_q;
  end

  assign out_valid = sb_vld[D];
  assign out0      = sb_dat[D];
  assign m_o       = sb_met[D];

`ifdef PIPED_SUB_MOD_RANGE_CHECK_EN
  // Updated on the same edge that raises out_valid for the offending operation.
  logic err_q;
  always_ff @(posedge clk) begin
    if (!rst) err_q <= 1'b0;
    else      err_q <= err_q | (sb_vld[D-1] & sb_bad[D-1]);
  end
  assign err_o = err_q;
`endif

endmodule

// File: tb/tb_piped_sub_mod.sv
// Scoreboard bench for piped_sub_mod: driver pushes expected results, negedge monitor pops and compares.
module tb_piped_sub_mod;

  localparam int W   = 384;
  localparam int M   = 1;
  localparam int LAT = 8;
  localparam logic [W-1:0] P = 384'h01ae3a4617c510eac63b05c06ca1493b1a22d9f300f5138f1ef3622fba094800170b5d44300000008508c00000000001;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         in_valid = 1'b0;
  logic [W-1:0] in0 = '0;
  logic [W-1:0] in1 = '0;
  logic [M-1:0] m_i = '0;
  logic         out_valid;
  logic [W-1:0] out0;
  logic [M-1:0] m_o;
`ifdef PIPED_SUB_MOD_RANGE_CHECK_EN
  logic         err_o;
`endif

  piped_sub_mod dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in0       (in0),
    .in1       (in1),
    .m_i       (m_i),
    .out_valid (out_valid),
    .out0      (out0),
    .m_o       (m_o)
`ifdef PIPED_SUB_MOD_RANGE_CHECK_EN
    ,
    .err_o     (err_o)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [W-1:0] res;
    logic [M-1:0] meta;
    logic         bad;
    int           due;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Golden model: subtract over the integers, add P back when the result would go negative.
  function automatic logic [W-1:0] ref_sub(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W:0] r;
    if (a >= b) r = {1'b0, a} - {1'b0, b};
    else        r = {1'b0, a} + {1'b0, P} - {1'b0, b};
    return r[W-1:0];
  endfunction

  function automatic logic [W-1:0] rand_red();
    logic [W-1:0] x;
    for (int i = 0; i < W / 32; i++) x[i*32 +: 32] = $urandom;
    return x % P;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [W-1:0] a, input logic [W-1:0] b, input logic [M-1:0] m);
    exp_t e;
    in_valid = v;
    in0      = a;
    in1      = b;
    m_i      = m;
    if (v && rst) begin
      e.res  = ref_sub(a, b);
      e.meta = m;
      e.bad  = (a >= P) || (b >= P);
      e.due  = cyc + LAT;
      sb_q.push_back(e);
    end
    step();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, rand_red(), rand_red(), M'($urandom));
  endtask

  task automatic drain();
    for (int k = 0; k < 4 * LAT && sb_q.size() > 0; k++) idle(1);
    check("drain_empty", W'(sb_q.size()), '0);
  endtask

  // Monitor: compare every presented result, flag unexpected or missing valids.
  logic err_exp = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (out_valid) begin
      if (sb_q.size() == 0) begin
        check("unexpected_valid", W'(out_valid), '0);
      end else begin
        e = sb_q.pop_front();
        check("out0", out0, e.res);
        check("m_o", W'(m_o), W'(e.meta));
        check("latency", W'(cyc), W'(e.due));
        err_exp = err_exp | e.bad;
`ifdef PIPED_SUB_MOD_RANGE_CHECK_EN
        check("err_o", W'(err_o), W'(err_exp));
`endif
      end
    end else if (sb_q.size() > 0 && sb_q[0].due <= cyc) begin
      e = sb_q.pop_front();
      check("missing_valid", W'(out_valid), W'(1));
    end
    if (!rst) err_exp = 1'b0;
  end

  initial begin
    // Reset and post-reset state.
    rst = 1'b0;
    drive(1'b1, 384'd9, 384'd4, 1'b1);
    idle(2);
    check("rst_out_valid", W'(out_valid), '0);
    check("rst_out0", out0, '0);
    check("rst_m_o", W'(m_o), '0);
`ifdef PIPED_SUB_MOD_RANGE_CHECK_EN
    check("rst_err_o", W'(err_o), '0);
`endif
    rst = 1'b1;

    // Single operation, then quiet pipe: exactly one valid pulse.
    drive(1'b1, 384'd5, 384'd3, 1'b1);
    idle(12);
    check("single_drained", W'(sb_q.size()), '0);

    // Directed boundaries, back-to-back.
    drive(1'b1, 384'd3, 384'd5, 1'b0);
    drive(1'b1, '0, P - 1, 1'b1);
    drive(1'b1, P - 1, P - 1, 1'b0);
    drive(1'b1, 384'd12345, 384'd12345, 1'b1);
    drive(1'b1, P - 1, '0, 1'b0);
    drive(1'b1, '0, 384'd1, 1'b1);
    drain();

    // 64 back-to-back random reduced pairs, metadata = index.
    for (int i = 0; i < 64; i++) drive(1'b1, rand_red(), rand_red(), M'(i));
    drain();

    // Random bubbles: order, latency and metadata alignment.
    for (int i = 0; i < 80; i++) drive(1'($urandom_range(0, 1)), rand_red(), rand_red(), M'($urandom));
    drain();

    // Reset mid-operation: in-flight ops dropped, op sampled during reset ignored.
    drive(1'b1, 384'd100, 384'd1, 1'b1);
    drive(1'b1, 384'd200, 384'd2, 1'b0);
    drive(1'b1, 384'd300, 384'd3, 1'b1);
    sb_q.delete();
    rst = 1'b0;
    drive(1'b1, 384'd400, 384'd4, 1'b0);
    rst = 1'b1;
    drive(1'b1, 384'd7, 384'd2, 1'b1);
    idle(14);
    check("post_rst_drained", W'(sb_q.size()), '0);

`ifdef PIPED_SUB_MOD_RANGE_CHECK_EN
    // Out-of-range operand: err_o rises with its result and stays set until reset.
    check("err_clear_before", W'(err_o), '0);
    drive(1'b1, P, '0, 1'b1);
    drive(1'b1, 384'd8, 384'd3, 1'b0);
    drain();
    drive(1'b1, rand_red(), rand_red(), 1'b1);
    drain();
    check("err_sticky", W'(err_o), W'(1));
    rst = 1'b0;
    idle(1);
    rst = 1'b1;
    check("err_cleared", W'(err_o), '0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish (cycle %0d)", cyc);
    $fatal(1);
  end

endmodule

// File: doc/piped_sub_mod.md
Name: piped_sub_mod

Overview:
- Pipelined modular subtractor: out0 = (in0 − in1) mod P, for operands already reduced (< P).
- Counterpart of the chunked carry-split piped_adder. Borrow ripples across 2^C chunks, one chunk per cycle. A second chunked stage then conditionally adds P back.
- Sits in the field-arithmetic datapath next to the adder and carry-save reducers. Feeds point-add/double pipelines.
- Accepts one operation per cycle. Sideband metadata travels with the data.

Parameters:
- W, 384, operand/result width in bits.
- C, 2, log2 of chunk count; D = 2^C chunks; chunk width = ceil(W/D); the last chunk takes the remainder.
- M, 1, width of the sideband metadata carried alongside the data.
- P, 384'h01ae3a4617c510eac63b05c06ca1493b1a22d9f300f5138f1ef3622fba094800170b5d44300000008508c00000000001, modulus (BLS12-377 base field).

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  reset, synchronous, active-low.
- in_valid  input  1  operands valid this cycle.
- in0  input  W  minuend, < P.
- in1  input  W  subtrahend, < P.
- m_i  input  M  metadata in.
- out_valid  output  1  result valid.
- out0  output  W  (in0 − in1) mod P.
- m_o  output  M  metadata, aligned with out0.
- err_o  output  1  sticky out-of-range flag; present only with the optional feature.

Behaviour:
- Fixed latency of 2·D cycles (8 at default) from in_valid to out_valid. Throughput is 1 per cycle. No backpressure; the consumer must always accept.

Stage A, cycles 1..D: subtraction.
- Cycle k subtracts chunk k−1 of in1 from chunk k−1 of in0, using the borrow registered from chunk k−2. The borrow-in for chunk 0 is 0.
- Chunks not yet processed are skew-delayed alongside.
- Result: raw difference d (W bits) and final borrow bA.

Stage B, cycles D+1..2D: correction.
- Adds (bA ? P : 0) to d, chunk-serially with a registered carry.
- The final carry out of the W-bit sum is discarded. When bA=1, d + P wraps to the correct value.

Data path rules:
- All arithmetic is modulo 2^W within the datapath.
- Each chunk adder is a single W/D-bit add/sub with carry in and carry out. There is no cross-chunk combinational path.
- in_valid, m_i and bA shift through the pipeline alongside the data; m_o is m_i delayed 2·D cycles.
- Data registers capture regardless of in_valid.
- out0 and m_o are don't-care-free: when out_valid=0 they hold whatever the pipe contains, and the bench must not check them then.

Reset:
- While rst=0 at a clock edge, all valid, borrow/carry, data and metadata registers clear.
- After reset, out_valid=0, out0=0, m_o=0, err_o=0.
- Reset mid-operation drops every in-flight operation; no out_valid emerges for it.
- in_valid sampled in a cycle with rst=0 is ignored.
- The first post-reset operation follows normal latency.

Boundaries:
- in0 = in1 gives 0 with no correction.
- in0 = 0, in1 = P−1 gives 1.
- Back-to-back and bubble-interleaved streams keep order and metadata alignment.
- Operands ≥ P produce an undefined-but-deterministic result; no error is reported without the feature.

Optional Feature:
Macro PIPED_SUB_MOD_RANGE_CHECK_EN.
- Defined:
  - Stage A additionally computes chunk-serial compares in0 ≥ P and in1 ≥ P, with the same skew as the subtraction.
  - When a valid operation with either compare true reaches the output, err_o is set at that out_valid cycle.
  - err_o stays 1 until reset; rst=0 clears it.
  - Latency and out0 are unchanged.
- Not defined: the err_o port does not exist and no compare logic is built.

Test Plan:
- Reset, then in0=5, in1=3, m_i=1 at cycle 0 → out_valid=1 at cycle 8, out0=2, m_o=1, with no other out_valid pulses.
- in0=3, in1=5 → out0=P−2. in0=0, in1=P−1 → out0=1. in0=in1=P−1 → out0=0.
- 64 back-to-back random reduced pairs with m_i = index → 64 consecutive out_valid cycles, each out0 matching the golden model (a−b) mod P, m_o in order.
- Stream with random in_valid gaps → output valid pattern equals the input pattern delayed 8, results correct.
- Issue 4 operations, assert rst=0 for 1 cycle at cycle 3, then issue in0=7, in1=2 → no output for the dropped operations; out0=5 exactly 8 cycles after the new issue.
- With PIPED_SUB_MOD_RANGE_CHECK_EN: in0=P, in1=0 → err_o rises with that out_valid and stays 1 through later valid operations until reset.
